// File: rtl/spi_register_bridge_pkg.sv
// Shared definitions for the SPI register bridge: FSM state encoding and
// command-byte field layout.
package spi_register_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WDATA   = 3'd2,
        ST_WCOMMIT = 3'd3,
        ST_RWAIT   = 3'd4,
        ST_RDATA   = 3'd5
    } state_e;

    localparam int CMD_W      = 8;  // command byte width
    localparam int CMD_W_BIT  = 7;  // 1 = write, 0 = read
    localparam int CMD_AI_BIT = 6;  // auto-increment address after each data byte
    localparam int CMD_ADDR_W = 6;  // address field in bits 5:0
    localparam int BITCNT_W   = 3;  // bit position within a byte

endpackage

// File: rtl/spi_register_bridge_input_sync.sv
// Brings the asynchronous SPI pins into the i_clk domain and produces
// registered SCLK rise/fall strokes aligned with the synchronised MOSI/CS_N.
// o_valid rises once the chains hold genuine pin samples, so reset values
// are never mistaken for a released chip select.
module spi_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sclk,
    input  logic i_cs_n,
    input  logic i_mosi,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_cs_n,
    output logic o_mosi,
    output logic o_valid
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   cs_n_q;
    logic                   mosi_q;
    logic [SYNC_STAGES:0]   fill_q;

    // Synchroniser chains plus one output register stage for edge detection.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            fill_q      <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            rise_q      <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
            fall_q      <= ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
            cs_n_q      <= cs_sync_q[SYNC_STAGES-1];
            mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
            fill_q      <= {fill_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign o_sclk_rise = rise_q;
    assign o_sclk_fall = fall_q;
    assign o_cs_n      = cs_n_q;
    assign o_mosi      = mosi_q;
    assign o_valid     = fill_q[SYNC_STAGES];

endmodule

// File: rtl/spi_register_bridge.sv
// SPI mode-0 slave that owns all host access to the register file:
// decodes the command byte, issues single-cycle writes and serves read data
// on MISO, with optional address auto-increment.
module spi_register_bridge
    import spi_register_bridge_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int RD_LAT      = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_spi_sclk,
    input  logic              i_spi_cs_n,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    output logic              o_write_en,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_busy,
    output logic              o_frame_err
);

    localparam int WAIT_W = $clog2(RD_LAT + 2);

    logic sclk_rise, sclk_fall, cs_n_s, mosi_s, sync_vld;

    spi_input_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_sclk     (i_spi_sclk),
        .i_cs_n     (i_spi_cs_n),
        .i_mosi     (i_spi_mosi),
        .o_sclk_rise(sclk_rise),
        .o_sclk_fall(sclk_fall),
        .o_cs_n     (cs_n_s),
        .o_mosi     (mosi_s),
        .o_valid    (sync_vld)
    );

    state_e              state_q, state_d;
    logic                armed_q, armed_d;
    logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                ai_q, ai_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    logic [DATA_W-1:0]   shift_in;
    logic                byte_done;

    assign shift_in  = {shift_q[DATA_W-2:0], mosi_s};
    assign byte_done = sclk_rise && (bitcnt_q == BITCNT_W'(CMD_W - 1));

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            armed_q  <= 1'b0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            out_q    <= '0;
            wdata_q  <= '0;
            addr_q   <= '0;
            ai_q     <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            armed_q  <= armed_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            out_q    <= out_d;
            wdata_q  <= wdata_d;
            addr_q   <= addr_d;
            ai_q     <= ai_d;
            we_q     <= we_d;
            err_q    <= err_d;
            wait_q   <= wait_d;
        end
    end

    // Next-state logic; a released chip select overrides any SCLK edge.
    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q | (cs_n_s & sync_vld);
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        out_d    = out_q;
        wdata_d  = wdata_q;
        addr_d   = addr_q;
        ai_d     = ai_q;
        we_d     = 1'b0;
        err_d    = 1'b0;
        wait_d   = wait_q;

        if (state_q != ST_IDLE && cs_n_s) begin
            state_d  = ST_IDLE;
            err_d    = (bitcnt_q != '0);
            bitcnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    bitcnt_d = '0;
                    if (armed_q && !cs_n_s) state_d = ST_CMD;
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        shift_d  = shift_in;
                        bitcnt_d = bitcnt_q + BITCNT_W'(1);
                        if (byte_done) begin
                            addr_d  = ADDR_W'(shift_in[CMD_ADDR_W-1:0]);
                            ai_d    = shift_in[CMD_AI_BIT];
                            wait_d  = '0;
                            state_d = shift_in[CMD_W_BIT] ? ST_WDATA : ST_RWAIT;
                        end
                    end
                end
                ST_WDATA: begin
                    if (sclk_rise) begin
                        shift_d  = shift_in;
                        bitcnt_d = bitcnt_q + BITCNT_W'(1);
                        if (byte_done) begin
                            wdata_d = shift_in;
                            we_d    = 1'b1;
                            state_d = ST_WCOMMIT;
                        end
                    end
                end
                ST_WCOMMIT: begin
                    if (ai_q) addr_d = addr_q + ADDR_W'(1);
                    state_d = ST_WDATA;
                end
                ST_RWAIT: begin
                    if (wait_q == WAIT_W'(RD_LAT)) begin
                        out_d   = i_rdata;
                        wait_d  = '0;
                        state_d = ST_RDATA;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                ST_RDATA: begin
                    // The fall trailing the previous byte arrives with bitcnt 0
                    // and must not disturb the freshly loaded MSB.
                    if (sclk_fall && bitcnt_q != '0) out_d = {out_q[DATA_W-2:0], 1'b0};
                    if (sclk_rise) begin
                        bitcnt_d = bitcnt_q + BITCNT_W'(1);
                        if (byte_done) begin
                            if (ai_q) addr_d = addr_q + ADDR_W'(1);
                            wait_d  = '0;
                            state_d = ST_RWAIT;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign o_spi_miso  = (state_q == ST_RDATA) & out_q[DATA_W-1];
    assign o_write_en  = we_q;
    assign o_address   = addr_q;
    assign o_wdata     = wdata_q;
    assign o_busy      = (state_q != ST_IDLE) & ~cs_n_s;
    assign o_frame_err = err_q;

endmodule

// File: tb/tb_spi_register_bridge.sv
// Bench for spi_register_bridge: drives SPI frames from a bit-banged master,
// predicts register writes and MISO bytes from the command-byte rules, and
// compares against the DUT with a register-file stub attached.
module tb_spi_register_bridge;

    localparam int ADDR_W = 6, DATA_W = 8, SYNC_STAGES = 2, RD_LAT = 1;
    localparam int HALF = 80;  // SCLK half period, 8 i_clk cycles

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              sclk, cs_n, mosi;
    logic              miso, we, busy, ferr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata, rdata;

    spi_register_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .RD_LAT(RD_LAT)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_spi_sclk (sclk),
        .i_spi_cs_n (cs_n),
        .i_spi_mosi (mosi),
        .o_spi_miso (miso),
        .o_write_en (we),
        .o_address  (addr),
        .o_wdata    (wdata),
        .i_rdata    (rdata),
        .o_busy     (busy),
        .o_frame_err(ferr)
    );

    always #5 i_clk = ~i_clk;

    // Register file stub with one cycle of read latency.
    logic [DATA_W-1:0] mem [64];
    always @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int k = 0; k < 64; k++) mem[k] <= '0;
            rdata <= '0;
        end else begin
            if (we) mem[addr] <= wdata;
            rdata <= mem[addr];
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [5:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  wr_seen  = 0;
    int  err_seen = 0;

    // Every write strobe must match the next predicted write.
    always @(negedge i_clk) begin : cmp
        wr_t e;
        if (i_reset === 1'b1) begin
            if (we) begin
                wr_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, expected none", addr, wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(addr), 32'(e.a));
                    check("write_data", 32'(wdata), 32'(e.d));
                end
            end
            if (ferr) err_seen++;
        end
    end

    // Behavioural model state
    logic [7:0] shadow [64];
    logic [7:0] tx_b [8];
    logic [7:0] rx_b [8];
    logic [7:0] exp_rx [8];
    int         exp_err;

    task automatic model_frame(input int nbytes, input int partial);
        logic [7:0] cmd;
        logic [5:0] a;
        cmd = tx_b[0];
        a   = cmd[5:0];
        for (int i = 0; i < 8; i++) exp_rx[i] = 8'h00;
        for (int i = 1; i < nbytes; i++) begin
            if (cmd[7]) begin
                exp_q.push_back('{a: a, d: tx_b[i]});
                shadow[a] = tx_b[i];
            end else begin
                exp_rx[i] = shadow[a];
            end
            if (cmd[6]) a = a + 6'd1;
        end
        exp_err = (partial != 0) ? 1 : 0;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = tx[7-i];
            #HALF;
            sclk = 1'b1;
            rx = {rx[6:0], miso};
            #HALF;
            sclk = 1'b0;
        end
    endtask

    task automatic do_frame(input int nbytes, input int partial);
        logic [7:0] dummy;
        int         e0;
        e0 = err_seen;
        @(negedge i_clk);
        #2;
        cs_n = 1'b0;
        #HALF;
        for (int i = 0; i < nbytes; i++) begin
            spi_bits(tx_b[i], 8, rx_b[i]);
            if (i == 0) check("busy_in_frame", 32'(busy), 32'd1);
        end
        if (partial > 0) spi_bits(tx_b[nbytes], partial, dummy);
        #HALF;
        cs_n = 1'b1;
        #400;
        for (int i = 0; i < nbytes; i++) check("miso_byte", 32'(rx_b[i]), 32'(exp_rx[i]));
        check("frame_err_count", 32'(err_seen - e0), 32'(exp_err));
        check("writes_pending", 32'(exp_q.size()), 32'd0);
        check("busy_after_frame", 32'(busy), 32'd0);
        check("miso_idle", 32'(miso), 32'd0);
    endtask

    task automatic frame(input int nbytes, input int partial);
        model_frame(nbytes, partial);
        do_frame(nbytes, partial);
    endtask

    initial begin
        int         w0;
        logic [7:0] junk;
        for (int k = 0; k < 64; k++) shadow[k] = 8'h00;

        // Reset with random pin values
        i_reset = 1'b0;
        sclk = 1'($urandom);
        cs_n = 1'($urandom);
        mosi = 1'($urandom);
        repeat (5) @(negedge i_clk);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_write_en", 32'(we), 32'd0);
        check("rst_address", 32'(addr), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_err", 32'(ferr), 32'd0);

        // Release with CS_N held low: clocks must be ignored
        #2;
        sclk = 1'b0;
        cs_n = 1'b0;
        i_reset = 1'b1;
        #HALF;
        spi_bits(8'h80, 8, junk);
        spi_bits(8'h05, 8, junk);
        check("no_arm_busy", 32'(busy), 32'd0);
        check("no_arm_writes", 32'(wr_seen), 32'd0);
        #HALF;
        cs_n = 1'b1;
        #400;
        check("no_arm_err", 32'(err_seen), 32'd0);

        // Single write
        w0 = wr_seen;
        tx_b[0] = 8'h80; tx_b[1] = 8'h05;
        frame(2, 0);
        check("lit_single_count", 32'(wr_seen - w0), 32'd1);
        check("lit_single_mem0", 32'(mem[0]), 32'h05);

        // Burst write with auto-increment
        w0 = wr_seen;
        tx_b[0] = 8'hC1; tx_b[1] = 8'h01; tx_b[2] = 8'h80; tx_b[3] = 8'h12;
        frame(4, 0);
        check("lit_burst_count", 32'(wr_seen - w0), 32'd3);
        check("lit_burst_mem1", 32'(mem[1]), 32'h01);
        check("lit_burst_mem2", 32'(mem[2]), 32'h80);
        check("lit_burst_mem3", 32'(mem[3]), 32'h12);

        // Address wrap 63 -> 0
        tx_b[0] = 8'hFF; tx_b[1] = 8'hAA; tx_b[2] = 8'hBB;
        frame(3, 0);
        check("lit_wrap_mem63", 32'(mem[63]), 32'hAA);
        check("lit_wrap_mem0", 32'(mem[0]), 32'hBB);

        // Burst read of addr 4,5 after loading them
        tx_b[0] = 8'hC4; tx_b[1] = 8'h0A; tx_b[2] = 8'h2A;
        frame(3, 0);
        w0 = wr_seen;
        tx_b[0] = 8'h44; tx_b[1] = 8'h00; tx_b[2] = 8'h00;
        frame(3, 0);
        check("lit_read_byte0", 32'(rx_b[1]), 32'h0A);
        check("lit_read_byte1", 32'(rx_b[2]), 32'h2A);
        check("lit_read_nowrite", 32'(wr_seen - w0), 32'd0);

        // Abort mid-byte, then a normal frame
        w0 = wr_seen;
        tx_b[0] = 8'h80; tx_b[1] = 8'h5C;
        frame(1, 5);
        check("lit_abort_nowrite", 32'(wr_seen - w0), 32'd0);
        tx_b[0] = 8'h85; tx_b[1] = 8'h77;
        frame(2, 0);
        check("lit_after_abort_mem5", 32'(mem[5]), 32'h77);

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            int nb, pb;
            nb = $urandom_range(1, 5);
            pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            for (int i = 0; i < 8; i++) tx_b[i] = 8'($urandom);
            frame(nb, pb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
